// File: rtl/ram_fifo_pkg.sv
// Shared definitions for the RAM-backed streaming FIFO controller:
// RAM operation encoding and the capacity helper.
package ram_fifo_pkg;

    localparam logic [1:0] OP_NONE  = 2'd0;
    localparam logic [1:0] OP_WRITE = 2'd1;
    localparam logic [1:0] OP_FETCH = 2'd2;

    // The output register holds one entry beyond the RAM depth.
    function automatic int unsigned fifo_capacity(input int unsigned a);
        return (32'd1 << a) + 32'd1;
    endfunction

endpackage

// File: rtl/ram_fifo_out_stage.sv
// One-entry output register of the RAM FIFO: loads from the RAM (or the
// bypass path), is consumed by the downstream stream handshake.
module ram_fifo_out_stage #(
    parameter int D = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         load,
    input  logic [D-1:0] load_data,
    input  logic         pop,
    output logic [D-1:0] out_data,
    output logic         out_valid,
    output logic         valid_nxt
);

    // A load in the same cycle as a pop keeps the register full.
    always_comb begin
        valid_nxt = out_valid;
        if (rst || clr)
            valid_nxt = 1'b0;
        else if (load)
            valid_nxt = 1'b1;
        else if (pop)
            valid_nxt = 1'b0;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            out_valid <= valid_nxt;
            if (load)
                out_data <= load_data;
        end
    end

endmodule

// File: rtl/ram_fifo_ctrl.sv
// Valid/ready FIFO controller driving an external single-port RAM
// (async read, sync write). Optional same-cycle bypass: RAM_FIFO_BYPASS_EN.
module ram_fifo_ctrl
    import ram_fifo_pkg::*;
#(
    parameter int A = 8,
    parameter int D = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic [D-1:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [D-1:0] out_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [A:0]   level,
    output logic [A-1:0] ram_address,
    output logic [D-1:0] ram_dbusi,
    input  logic [D-1:0] ram_dbuso,
    output logic         ram_ce,
    output logic         ram_we
);

    localparam logic [A:0] DEPTH = (A+1)'(fifo_capacity(A) - 1);

    logic [A-1:0] wr_ptr, rd_ptr, addr_q;
    logic [A:0]   ram_count, ram_count_nxt;
    logic [D-1:0] dbusi_q;
    logic [1:0]   op;
    logic         fetch, push, bypass, load, ov_nxt;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        fetch    = !rst && !flush && (ram_count != '0) && (!out_valid || out_ready);
        in_ready = !rst && !flush && (ram_count < DEPTH) && !fetch;
        push     = in_valid && in_ready;
`ifdef RAM_FIFO_BYPASS_EN
        bypass   = push && (ram_count == '0) && (!out_valid || out_ready);
`else
        bypass   = 1'b0;
`endif
        op = OP_NONE;
        if (fetch)
            op = OP_FETCH;
        else if (push && !bypass)
            op = OP_WRITE;

        ram_ce      = (op != OP_NONE);
        ram_we      = (op == OP_WRITE);
        ram_address = addr_q;
        ram_dbusi   = dbusi_q;
        case (op)
            OP_FETCH: ram_address = rd_ptr;
            OP_WRITE: begin
                ram_address = wr_ptr;
                ram_dbusi   = in_data;
            end
            default: ;
        endcase

        load          = fetch || bypass;
        ram_count_nxt = ram_count;
        if (rst || flush)
            ram_count_nxt = '0;
        else if (op == OP_FETCH)
            ram_count_nxt = ram_count - (A+1)'(1);
        else if (op == OP_WRITE)
            ram_count_nxt = ram_count + (A+1)'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            ram_count <= '0;
            level     <= '0;
            addr_q    <= '0;
            dbusi_q   <= '0;
        end else begin
            addr_q    <= ram_address;
            dbusi_q   <= ram_dbusi;
            ram_count <= ram_count_nxt;
            level     <= ram_count_nxt + (A+1)'(ov_nxt);
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (op == OP_FETCH)
                    rd_ptr <= rd_ptr + A'(1);
                if (op == OP_WRITE)
                    wr_ptr <= wr_ptr + A'(1);
            end
        end
    end

    ram_fifo_out_stage #(.D(D)) u_out_stage (
        .clk       (clk),
        .rst       (rst),
        .clr       (flush),
        .load      (load),
        .load_data (bypass ? in_data : ram_dbuso),
        .pop       (out_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .valid_nxt (ov_nxt)
    );

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Randomized bench for ram_fifo_ctrl (A=2): queue-based reference model
// plus an output-order scoreboard; RAM modelled beside the controller.
module tb_ram_fifo_ctrl;

    localparam int A     = 2;
    localparam int D     = 8;
    localparam int DEPTH = 4;
`ifdef RAM_FIFO_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst, flush, in_valid, in_ready, out_valid, out_ready, ram_ce, ram_we;
    logic [D-1:0] in_data, out_data, ram_dbusi, ram_dbuso;
    logic [A:0]   level;
    logic [A-1:0] ram_address;
    logic [D-1:0] mem [DEPTH];

    int vectors     = 0;
    int miscompares = 0;
    bit started     = 1'b0;

    logic [7:0] exp_q [$];   // scoreboard: accepted entries in order
    logic [7:0] ram_q [$];   // model: entries resident in RAM
    bit         m_ov;
    logic [7:0] m_od;
    int         wr_n, rd_n;

    always #5 clk = ~clk;

    assign ram_dbuso = mem[ram_address];
    always @(posedge clk) if (ram_ce && ram_we) mem[ram_address] <= ram_dbusi;

    ram_fifo_ctrl #(.A(A), .D(D)) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .level       (level),
        .ram_address (ram_address),
        .ram_dbusi   (ram_dbusi),
        .ram_dbuso   (ram_dbuso),
        .ram_ce      (ram_ce),
        .ram_we      (ram_we)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic clear_model();
        ram_q.delete();
        exp_q.delete();
        m_ov = 1'b0;
        wr_n = 0;
        rd_n = 0;
    endtask

    // Reference model: one call per cycle with the cycle's inputs stable.
    task automatic step();
        bit fetch, byp, rdy, push, ce, we;
        check("level", 32'(level), 32'(ram_q.size()) + 32'(m_ov));
        check("out_valid", 32'(out_valid), 32'(m_ov));
        if (m_ov) check("out_data", 32'(out_data), 32'(m_od));
        if (rst || flush) begin
            check("in_ready_clr", 32'(in_ready), 32'(0));
            check("ram_ce_clr", 32'(ram_ce), 32'(0));
            check("ram_we_clr", 32'(ram_we), 32'(0));
            clear_model();
            if (rst) m_od = 8'h00;
        end else begin
            fetch = (ram_q.size() > 0) && (!m_ov || out_ready);
            byp   = BYP && (ram_q.size() == 0) && (!m_ov || out_ready) && in_valid;
            rdy   = (ram_q.size() < DEPTH) && !fetch;
            push  = in_valid && rdy;
            ce    = fetch || (push && !byp);
            we    = !fetch && push && !byp;
            check("in_ready", 32'(in_ready), 32'(rdy));
            check("ram_ce", 32'(ram_ce), 32'(ce));
            check("ram_we", 32'(ram_we), 32'(we));
            if (fetch) check("fetch_addr", 32'(ram_address), 32'(rd_n % DEPTH));
            if (we) begin
                check("write_addr", 32'(ram_address), 32'(wr_n % DEPTH));
                check("write_data", 32'(ram_dbusi), 32'(in_data));
            end
            if (fetch) begin
                m_od = ram_q.pop_front();
                m_ov = 1'b1;
                rd_n++;
            end else if (byp) begin
                m_od = in_data;
                m_ov = 1'b1;
            end else if (m_ov && out_ready) begin
                m_ov = 1'b0;
            end
            if (push && !byp) begin
                ram_q.push_back(in_data);
                wr_n++;
            end
            if (push) exp_q.push_back(in_data);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (started) step();
        end
    end

    // Monitor: every consumed output must be the oldest outstanding entry.
    always @(negedge clk) begin
        if (started && !rst && !flush && out_valid && out_ready) begin
            if (exp_q.size() == 0)
                check("pop_when_empty", 32'(exp_q.size()), 32'(1));
            else
                check("out_order", 32'(out_data), 32'(exp_q.pop_front()));
        end
    end

    task automatic drive(input bit r, input bit f, input bit v, input logic [7:0] d,
                         input bit o, output bit acc);
        rst = r; flush = f; in_valid = v; in_data = d; out_ready = o;
        #1;
        acc = v && in_ready;
        @(posedge clk);
        #1;
    endtask

    task automatic push_n(input logic [7:0] base, input int n, input bit o);
        int k = 0;
        bit acc;
        for (int t = 0; t < 80 && k < n; t++) begin
            drive(0, 0, 1, base + 8'(k), o, acc);
            if (acc) k++;
        end
        check("push_budget", 32'(k), 32'(n));
    endtask

    task automatic idle(input int n, input bit o);
        bit acc;
        for (int t = 0; t < n; t++) drive(0, 0, 0, 8'h00, o, acc);
    endtask

    initial begin
        bit acc;
        clear_model();
        m_od = 8'h00;
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        @(posedge clk);
        #1;
        started = 1'b1;
        drive(1, 0, 0, 8'h00, 0, acc);

        // single entry latency, then fill to capacity and drain
        push_n(8'h11, 1, 0);
        idle(3, 0);
        idle(2, 1);
        for (int i = 1; i <= 6; i++) drive(0, 0, 1, 8'(i), 0, acc);
        idle(2, 0);
        idle(12, 1);

        // continuous stream across pointer wrap
        push_n(8'hA0, 10, 1);
        idle(6, 1);

        // flush with three entries held, then first entry after flush
        push_n(8'h30, 3, 0);
        idle(2, 0);
        drive(0, 1, 1, 8'h77, 0, acc);
        push_n(8'hAA, 1, 0);
        idle(4, 1);

        // reset with three entries held
        push_n(8'h40, 3, 0);
        idle(2, 0);
        drive(1, 0, 1, 8'h55, 0, acc);
        idle(2, 1);

        // randomized traffic with occasional flush and reset
        for (int t = 0; t < 600; t++) begin
            bit r = ($urandom_range(0, 99) == 0);
            bit f = !r && ($urandom_range(0, 39) == 0);
            bit v = ($urandom_range(0, 9) < 7);
            bit o = !r && !f && ($urandom_range(0, 9) < 6);
            drive(r, f, v, 8'($urandom), o, acc);
        end

        idle(20, 1);
        check("scoreboard_empty", 32'(exp_q.size()), 32'(0));
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ram_fifo_ctrl.md
Name: ram_fifo_ctrl

Overview:
- FIFO controller that sits directly upstream of the single-port RAM unit: async read, sync write, one `address`, `ce`/`we` strobes.
- Turns the RAM into a valid/ready streaming FIFO.
- Owns read/write pointers, occupancy and a one-entry output register, so a pop never needs the RAM port in the same cycle.
- Sits between a producer stream and a consumer stream; the RAM is instantiated beside it in the parent.

Parameters:
- `A`, 8, RAM address width. RAM depth is 2**A; total FIFO capacity is 2**A + 1.
- `D`, 8, data width.

Ports:
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  synchronous, active-high reset
- `flush`  in  1  synchronous clear of FIFO contents
- `in_data`  in  D  producer data
- `in_valid`  in  1  producer has data
- `in_ready`  out  1  controller accepts `in_data` this cycle
- `out_data`  out  D  output register contents
- `out_valid`  out  1  `out_data` holds an entry
- `out_ready`  in  1  consumer takes the entry
- `level`  out  A+1  entries held (RAM count + `out_valid`)
- `ram_address`  out  A  to RAM `address`
- `ram_dbusi`  out  D  to RAM `dbusi`
- `ram_dbuso`  in  D  from RAM `dbuso` (combinational read)
- `ram_ce`  out  1  to RAM `ce`
- `ram_we`  out  1  to RAM `we`

Behaviour:
- Internal state: `wr_ptr`/`rd_ptr` (A bits, wrap modulo 2**A); `ram_count` (A+1 bits, 0..2**A); `out_valid`/`out_data` registers.
- Reset (`rst`=1):
  - Next edge: pointers, `ram_count`, `out_valid`, `out_data`, `level` all return to 0.
  - While `rst` is high: `in_ready`=0, `ram_ce`=0, `ram_we`=0.
  - Reset mid-transfer discards all data.
- One RAM op per cycle, chosen combinationally each cycle: OP_NONE, OP_FETCH or OP_WRITE.
- `fetch` = (`ram_count`≠0) & (!`out_valid` | `out_ready`). OP_FETCH has priority over OP_WRITE.
- `in_ready` = !`rst` & !`flush` & (`ram_count`<2**A) & !`fetch`.
- OP_FETCH:
  - Drives `ram_ce`=1, `ram_we`=0, `ram_address`=`rd_ptr`.
  - At the edge: `out_data`<=`ram_dbuso`, `out_valid`<=1, `rd_ptr`++, `ram_count`--.
- OP_WRITE (`in_valid` & `in_ready`):
  - Drives `ram_ce`=1, `ram_we`=1, `ram_address`=`wr_ptr`, `ram_dbusi`=`in_data`.
  - At the edge: `wr_ptr`++, `ram_count`++.
- OP_NONE: `ram_ce`=0, `ram_we`=0; `ram_address`/`ram_dbusi` hold the last values (don't-care).
- Pop:
  - `out_valid` & `out_ready` consumes the entry.
  - If `fetch` is also true, the register reloads in the same edge and `out_valid` stays 1; otherwise `out_valid`<=0.
- Latency without bypass: push accepted at T, fetched at T+1, `out_valid`=1 at T+2. Throughput is 1 entry per 2 cycles when producer and consumer are both continuous.
- Full: `ram_count`=2**A → `in_ready`=0. Push attempts are ignored (no overwrite).
- Empty: `ram_count`=0 and `out_valid`=0 → `level`=0; `out_ready` is ignored.
- Pointer wrap: 2**A−1 → 0, no special handling; ordering is preserved.
- `flush`=1:
  - Overrides everything: `ram_ce`=0, `in_ready`=0.
  - Next edge clears pointers, `ram_count` and `out_valid`; `out_data` is held.
- `level` is registered: updated at every edge to the next (`ram_count` + `out_valid`).

Optional Feature:
- Macro: `RAM_FIFO_BYPASS_EN`.
- Defined:
  - Condition: `ram_count`=0, (!`out_valid` | `out_ready`), `in_valid`, no `flush`.
  - Action: `in_data` loads `out_data` directly and `out_valid`<=1 next edge.
  - No RAM access that cycle (`ram_ce`=0); `in_ready`=1.
  - Push-to-`out_valid` latency becomes 1 cycle.
- Undefined: every entry passes through the RAM; latency is 2 cycles.

Decomposition:
- Package `ram_fifo_pkg`:
  - Op encoding localparams OP_NONE=2'd0, OP_WRITE=2'd1, OP_FETCH=2'd2.
  - Function for capacity (2**A + 1).
- Natural sub-module `ram_fifo_out_stage`: the one-entry output register with load/pop logic and `out_valid`.
- Pointer/arbitration logic stays in the top module.
- The RAM unit is not instantiated inside; the parent connects the `ram_*` ports.

Test Plan (A=2, D=8, capacity 5, bypass off unless stated):
1. Reset, then push 0x11 at cycle 0 → cycle 0 `ram_we`=1 `ram_address`=0; cycle 1 `ram_ce`=1 `ram_we`=0; cycle 2 `out_valid`=1 `out_data`=0x11, `level`=1.
2. `out_ready`=0, push 0x01..0x06 → five accepted, `in_ready`=0 for 0x06, `level`=5; drain yields 0x01..0x05 in order, `level` reaches 0.
3. Stream 10 entries 0xA0..0xA9 with `out_ready`=1 → `ram_address` wraps 3→0 on writes and fetches, output order exact, no loss or duplication.
4. `out_valid`=1, `out_ready`=1, `ram_count`=2, `in_valid`=1 → that cycle `in_ready`=0, `ram_we`=0, OP_FETCH issued, `out_valid` stays 1.
5. `level`=3 then `flush`=1 for one cycle → next cycle `out_valid`=0, `level`=0; push 0xAA afterwards is the first entry out.
6. With `RAM_FIFO_BYPASS_EN`, empty FIFO, push 0x5A → `ram_ce` stays 0, next cycle `out_valid`=1 `out_data`=0x5A; `rst` asserted with 3 entries → next cycle `level`=0, `out_valid`=0.
